// File: rtl/fetch_unit_if.sv
// Fetch-to-memory / fetch-to-decode bundle. The fetch unit owns the "master"
// view (drives address and the decode-side word); the surrounding memory and
// decode logic use the "slave" view.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 29
);
  logic               in_start;
  logic               in_branch_valid;
  logic [ADDR_W-1:0]  in_branch_target;
  logic [ADDR_W-1:0]  out_add;
  logic [INSTR_W-1:0] in_instruction;
  logic [INSTR_W-1:0] out_instruction;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_valid;
  logic               in_ready;
  logic               out_halted;

  modport master (
    input  in_start, in_branch_valid, in_branch_target, in_instruction, in_ready,
    output out_add, out_instruction, out_pc, out_valid, out_halted
  );

  modport slave (
    output in_start, in_branch_valid, in_branch_target, in_instruction, in_ready,
    input  out_add, out_instruction, out_pc, out_valid, out_halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the program counter, addresses program memory
// directly (memory answers combinationally), captures the returned word into an
// instruction register and offers it to decode over valid/ready. A branch
// flushes the held word and redirects; a halt opcode stops further fetching.
module fetch_unit #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INSTR_W     = 29,
  parameter int unsigned       OPC_W       = 5,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = 8'd0,
  parameter logic [OPC_W-1:0]  HALT_OPCODE = 5'b11111
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               load_s;
  logic               halt_word_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  instr_pc_r;
  logic               valid_r;
  logic               halted_r;

  // True when the word carries the opcode that ends fetching.
  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return (word[INSTR_W-1 -: OPC_W] == HALT_OPCODE);
  endfunction

  // Load decision and next-state selection; branch outranks everything else.
  always_comb begin
    state_s     = state_r;
    halt_word_s = is_halt(bus.in_instruction);
    load_s      = (state_r == ST_FETCH) && (!valid_r || bus.in_ready) &&
                  !bus.in_branch_valid;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_branch_valid || bus.in_start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.in_branch_valid) begin
          state_s = ST_FETCH;
        end else if (load_s && halt_word_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (bus.in_branch_valid) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, instruction register and handshake valid; halted flag tracks next state.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pc_r       <= RESET_ADDR;
      instr_r    <= {INSTR_W{1'b0}};
      instr_pc_r <= {ADDR_W{1'b0}};
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      halted_r <= (state_s == ST_HALT);
      if (bus.in_branch_valid) begin
        // Redirect: the held word is dropped even if decode is taking it.
        pc_r    <= bus.in_branch_target;
        valid_r <= 1'b0;
      end else if (load_s) begin
        instr_r    <= bus.in_instruction;
        instr_pc_r <= pc_r;
        valid_r    <= 1'b1;
        pc_r       <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (valid_r && bus.in_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.out_add         = pc_r;
  assign bus.out_instruction = instr_r;
  assign bus.out_pc          = instr_pc_r;
  assign bus.out_valid       = valid_r;
  assign bus.out_halted      = halted_r;

endmodule
